blink_tick_gen: RTL
===================

Name: blink_tick_gen

Overview:
- Upstream enable source for the 4-LED rotator; the rotator advances one quarter-turn per rising edge of its enable input.
- Divides the board clock into periodic enable pulses with a fixed pulse width.
- Provides four selectable speeds, stepped by a debounced push-button, and a run/pause switch.
- Outputs drive the rotator's enable input directly; speed and running are for status LEDs or debug.

Parameters:
- CLK_HZ, 12000000: board clock frequency. Base period in clock cycles at speed 0.
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles required to accept a new button level (10 ms at 12 MHz).
- PULSE_CYCLES, 4: width of each enable pulse, in clock cycles. Constraint: 1 <= PULSE_CYCLES < (CLK_HZ >> 3).

Ports:
- clk  input  1  board clock
- reset  input  1  asynchronous, active-high reset
- btn  input  1  raw speed-step push-button (asynchronous, bouncy, active-high)
- run  input  1  raw run/pause switch (asynchronous, 1 = run)
- enable  output  1  periodic pulse to the LED rotator
- speed  output  2  current speed index, 0..3
- running  output  1  1 while state is COUNT

Behaviour:
- Reset (async, active-high):
  - enable=0, speed=0, running=0.
  - Period counter cnt=0, pulse counter=0, debounced button level=0, all synchronizer flops=0, state=PAUSED.
  - Reset asserted mid-pulse drops enable immediately.
- Input synchronizers:
  - btn and run each pass through 2 flops, giving btn_s and run_s.
  - Latency is 2 cycles; only the _s versions are used internally.
- Debounce:
  - Counter runs while btn_s differs from the debounced level; it clears whenever btn_s equals that level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still different, the debounced level takes btn_s and the counter clears.
  - A 0->1 transition of the debounced level produces a one-cycle step pulse. Release produces nothing.
- Speed:
  - On a step pulse, speed <= speed+1, wrapping 3->0.
  - Period P = CLK_HZ >> speed: speed 0 = 1 s, 1 = 0.5 s, 2 = 0.25 s, 3 = 0.125 s at 12 MHz.
  - In the same cycle speed changes, cnt is cleared to 0.
  - A pulse already in progress finishes its full width.
- State machine (2 states, PAUSED and COUNT):
  - PAUSED: cnt held at 0, no new pulse starts. Goes to COUNT on the next edge when run_s=1.
  - COUNT: cnt increments every cycle. When cnt==P-1, cnt <= 0 and a pulse is started. Goes to PAUSED on the next edge when run_s=0.
  - When COUNT is left, cnt is cleared.
- Pulse generation:
  - Starting a pulse loads the pulse counter. enable is high for exactly PULSE_CYCLES cycles, beginning the cycle after cnt==P-1.
  - cnt keeps running during the pulse, so the rising-edge-to-rising-edge interval is exactly P cycles.
  - enable is registered (glitch-free).
  - If the state goes to PAUSED mid-pulse, the pulse still completes its full width.
- First pulse after entering COUNT: its rising edge is exactly P cycles after the COUNT entry edge.
- Simultaneous events:
  - A step pulse in the same cycle as cnt==P-1: the speed change wins. cnt clears, no pulse starts, and the next pulse follows the new P.
  - run_s falling in the same cycle as cnt==P-1: the pulse starts and completes, then the state is PAUSED.
- Width rules: cnt is sized $clog2(CLK_HZ) bits. The P comparison uses that width, with no truncation.

Test Plan (bench params CLK_HZ=64, DEBOUNCE_CYCLES=4, PULSE_CYCLES=2; P = 64/32/16/8):
- Reset, run=1 held, btn=0. Expected: enable rising edge 67 cycles after reset release (2 sync + 1 state + 64). Then rising edges every 64 cycles, each exactly 2 cycles high. speed=0, running=1.
- btn bounces (1-cycle and 3-cycle highs separated by lows), then stays low. Expected: speed stays 0 and the enable period stays 64.
- btn held high 10 cycles. Expected: speed=1 exactly once, cnt clears, next enable rising edges 32 cycles apart. Three more clean presses give speed 2, then 3 (period 8), then 0 (period 64).
- run=0 asserted while enable is high. Expected: pulse completes its 2 cycles, running=0 three cycles after the run edge, no further pulses. run=1 again: first rising edge 64 cycles after COUNT is re-entered.
- Step pulse aligned to the cycle cnt==63. Expected: no pulse that cycle, speed=1, next rising edge 33 cycles later (32-cycle count after the clear, plus 1 for the registered enable).
- reset asserted asynchronously mid-pulse at speed 2. Expected: enable=0, speed=0 and running=0 immediately. After release with run=1, the first edge follows at the 67-cycle timing.

Source files
------------

// File: rtl/blink_tick_gen.sv
// Periodic enable-pulse generator for the 4-LED rotator.
// Four button-stepped speeds (period = CLK_HZ >> speed) and a run/pause switch.
module blink_tick_gen #(
    parameter int unsigned CLK_HZ          = 12000000,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       run,
    output logic       enable,
    output logic [1:0] speed,
    output logic       running
);

    localparam int unsigned CNT_W = $clog2(CLK_HZ);
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PLS_W = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [0:0] {
        PAUSED = 1'b0,
        COUNT  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               btn_meta_q, btn_meta_d;
    logic               btn_s_q, btn_s_d;
    logic               run_meta_q, run_meta_d;
    logic               run_s_q, run_s_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               btn_db_q, btn_db_d;
    logic               step_q, step_d;
    logic [1:0]         speed_q, speed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PLS_W-1:0]   pls_q, pls_d;
    logic               enable_q, enable_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   period_m1_c;
    logic               pls_start_c;

    // Two-flop synchronizers for the asynchronous button and switch.
    always_comb begin
        btn_meta_d = btn;
        btn_s_d    = btn_meta_q;
        run_meta_d = run;
        run_s_d    = run_meta_q;
    end

    // Debounce: accept a new button level after DEBOUNCE_CYCLES stable cycles; step on press only.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        step_d   = 1'b0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 32'd1)) begin
                btn_db_d = btn_s_q;
                step_d   = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Terminal count for the current speed; always fits in CNT_W bits.
    always_comb begin
        period_m1_c = CNT_W'((CLK_HZ >> speed_q) - 32'd1);
    end

    // Run/pause FSM, period counter and speed stepping; a speed step beats a pulse start.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        speed_d     = speed_q;
        pls_start_c = 1'b0;
        if (step_q) begin
            speed_d = speed_q + 2'd1;
        end
        case (state_q)
            PAUSED: begin
                cnt_d = '0;
                if (run_s_q) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (step_q) begin
                    cnt_d = '0;
                end else if (cnt_q == period_m1_c) begin
                    cnt_d       = '0;
                    pls_start_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!run_s_q) begin
                    state_d = PAUSED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PAUSED;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulse width counter; a started pulse always runs to full width.
    always_comb begin
        pls_d = '0;
        if (pls_start_c) begin
            pls_d = PLS_W'(PULSE_CYCLES);
        end else if (pls_q != '0) begin
            pls_d = pls_q - PLS_W'(1);
        end
        enable_d  = (pls_d != '0);
        running_d = (state_d == COUNT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PAUSED;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b0;
            step_q     <= 1'b0;
            speed_q    <= '0;
            cnt_q      <= '0;
            pls_q      <= '0;
            enable_q   <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            run_meta_q <= run_meta_d;
            run_s_q    <= run_s_d;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            step_q     <= step_d;
            speed_q    <= speed_d;
            cnt_q      <= cnt_d;
            pls_q      <= pls_d;
            enable_q   <= enable_d;
            running_q  <= running_d;
        end
    end

    assign enable  = enable_q;
    assign speed   = speed_q;
    assign running = running_q;

endmodule
